// File: rtl/ccff_chain_loader_if.sv
// rtl/ccff_chain_loader_if.sv - bitstream word handshake between host and chain loader
interface ccff_chain_loader_if #(
    parameter int WORD_W = 8
);
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_ready;

    modport master (
        output cfg_data,
        output cfg_valid,
        input  cfg_ready
    );

    modport slave (
        input  cfg_data,
        input  cfg_valid,
        output cfg_ready
    );
endinterface

// File: rtl/ccff_chain_loader.sv
// rtl/ccff_chain_loader.sv - serializes bitstream words onto a ccff scan chain with optional verify pass
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 29,
    parameter int WORD_W    = 8
) (
    input  logic                 prog_clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 verify,
    input  logic                 abort,
    ccff_chain_loader_if.slave   cfg,
    output logic                 ccff_head,
    input  logic                 ccff_tail,
    output logic                 ccff_shift_en,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [7:0]           err_count
);

    // Pass counter must reach CHAIN_LEN; word counter must reach WORD_W.
    localparam int CW = $clog2(CHAIN_LEN + 1);
    localparam int WB = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   buf_q, buf_d;
    logic [CW-1:0]       pass_bits_q, pass_bits_d;
    logic [WB-1:0]       word_bits_q, word_bits_d;
    logic [WB-1:0]       nbits_q, nbits_d;
    logic                pass_q, pass_d;
    logic                verify_q, verify_d;
    logic                cfg_ready_q, cfg_ready_d;
    logic                ccff_head_q, ccff_head_d;
    logic                ccff_shift_en_q, ccff_shift_en_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [7:0]          err_count_q, err_count_d;
    logic [CW-1:0]       remaining;

    // State and registered outputs; everything returns to idle on reset.
    always_ff @(posedge prog_clk or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_IDLE;
            buf_q           <= '0;
            pass_bits_q     <= '0;
            word_bits_q     <= '0;
            nbits_q         <= '0;
            pass_q          <= 1'b0;
            verify_q        <= 1'b0;
            cfg_ready_q     <= 1'b0;
            ccff_head_q     <= 1'b0;
            ccff_shift_en_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            err_q           <= 1'b0;
            err_count_q     <= '0;
        end else begin
            state_q         <= state_d;
            buf_q           <= buf_d;
            pass_bits_q     <= pass_bits_d;
            word_bits_q     <= word_bits_d;
            nbits_q         <= nbits_d;
            pass_q          <= pass_d;
            verify_q        <= verify_d;
            cfg_ready_q     <= cfg_ready_d;
            ccff_head_q     <= ccff_head_d;
            ccff_shift_en_q <= ccff_shift_en_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            err_q           <= err_d;
            err_count_q     <= err_count_d;
        end
    end

    // Next state; outputs are computed for the state being entered so they register cleanly.
    always_comb begin
        state_d         = state_q;
        buf_d           = buf_q;
        pass_bits_d     = pass_bits_q;
        word_bits_d     = word_bits_q;
        nbits_d         = nbits_q;
        pass_d          = pass_q;
        verify_d        = verify_q;
        cfg_ready_d     = 1'b0;
        ccff_head_d     = 1'b0;
        ccff_shift_en_d = 1'b0;
        done_d          = done_q;
        err_d           = err_q;
        err_count_d     = err_count_q;
        remaining       = CW'(CHAIN_LEN) - pass_bits_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    verify_d    = verify;
                    done_d      = 1'b0;
                    err_d       = 1'b0;
                    err_count_d = '0;
                    pass_bits_d = '0;
                    word_bits_d = '0;
                    pass_d      = 1'b0;
                    state_d     = ST_FETCH;
                    cfg_ready_d = 1'b1;
                end
            end

            ST_FETCH: begin
                if (cfg.cfg_valid && cfg_ready_q) begin
                    buf_d           = cfg.cfg_data;
                    word_bits_d     = '0;
                    // The last word of a pass only contributes the bits still missing.
                    if (32'(remaining) < WORD_W) begin
                        nbits_d = WB'(remaining);
                    end else begin
                        nbits_d = WB'(WORD_W);
                    end
                    ccff_head_d     = cfg.cfg_data[0];
                    ccff_shift_en_d = 1'b1;
                    state_d         = ST_SHIFT;
                end else begin
                    cfg_ready_d = 1'b1;
                end
            end

            ST_SHIFT: begin
                // The tail shows the bit shifted CHAIN_LEN enables ago, i.e. the pass-0 copy.
                if (pass_q && (ccff_tail != ccff_head_q)) begin
                    err_d = 1'b1;
                    if (err_count_q != 8'hFF) begin
                        err_count_d = err_count_q + 8'd1;
                    end
                end
                buf_d       = buf_q >> 1;
                word_bits_d = word_bits_q + WB'(1);
                pass_bits_d = pass_bits_q + CW'(1);
                if ((word_bits_q + WB'(1)) < nbits_q) begin
                    ccff_head_d     = buf_q[1];
                    ccff_shift_en_d = 1'b1;
                end else if ((pass_bits_q + CW'(1)) < CW'(CHAIN_LEN)) begin
                    state_d     = ST_FETCH;
                    cfg_ready_d = 1'b1;
                end else if (!pass_q && verify_q) begin
                    pass_d      = 1'b1;
                    pass_bits_d = '0;
                    state_d     = ST_FETCH;
                    cfg_ready_d = 1'b1;
                end else begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort wins over everything, leaving the error record untouched.
        if (abort) begin
            state_d         = ST_IDLE;
            cfg_ready_d     = 1'b0;
            ccff_shift_en_d = 1'b0;
            ccff_head_d     = 1'b0;
            done_d          = 1'b0;
            verify_d        = verify_q;
            err_d           = err_q;
            err_count_d     = err_count_q;
        end

        busy_d = (state_d == ST_FETCH) || (state_d == ST_SHIFT);
    end

    assign cfg.cfg_ready  = cfg_ready_q;
    assign ccff_head      = ccff_head_q;
    assign ccff_shift_en  = ccff_shift_en_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
    assign err_count      = err_count_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb/tb_ccff_chain_loader.sv - directed self-checking bench for ccff_chain_loader
module tb_ccff_chain_loader;

    localparam int CL = 29;
    localparam logic [28:0] EXP_CHAIN = {5'h15, 8'hFF, 8'h3C, 8'hA5};

    logic        prog_clk;
    logic        reset;
    logic        start;
    logic        verify;
    logic        abort;
    logic        ccff_head;
    logic        ccff_tail;
    logic        ccff_shift_en;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  err_count;

    ccff_chain_loader_if #(.WORD_W(8)) cfg_if ();

    ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(8)) dut (
        .prog_clk      (prog_clk),
        .reset         (reset),
        .start         (start),
        .verify        (verify),
        .abort         (abort),
        .cfg           (cfg_if),
        .ccff_head     (ccff_head),
        .ccff_tail     (ccff_tail),
        .ccff_shift_en (ccff_shift_en),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .err_count     (err_count)
    );

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          en_cnt = 0;
    int          en_base = 0;
    int          stall_bad = 0;
    int          stall_cyc = 0;
    int          dc;
    int          widx;
    int          stall_cnt;
    logic        pend;
    logic        stalling;
    logic        stall_mode;
    logic        inj_en;
    logic        inj;
    logic [28:0] chain = '0;
    logic [7:0]  words [4];

    initial begin
        prog_clk = 1'b0;
        forever #5 prog_clk = ~prog_clk;
    end

    // Chain model: CL flops, head enters at the top, tail leaves at bit 0.
    always @(posedge prog_clk) begin
        if (ccff_shift_en) begin
            chain  <= {ccff_head, chain[28:1]};
            en_cnt <= en_cnt + 1;
        end
        if (stalling) begin
            stall_cyc <= stall_cyc + 1;
            if (ccff_shift_en) stall_bad <= stall_bad + 1;
        end
    end

    // Fault injection on pass-1 bits 3 and 20.
    always_comb begin
        inj = inj_en && ((en_cnt - en_base - CL == 3) || (en_cnt - en_base - CL == 20));
    end
    assign ccff_tail = chain[0] ^ inj;

    // Host model: sends the four words in order, optionally stalling 5 cycles per FETCH.
    initial begin
        words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF; words[3] = 8'h15;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_data  = '0;
        widx = 0; pend = 1'b0; stall_cnt = 0; stalling = 1'b0;
        forever begin
            @(negedge prog_clk);
            if (pend) begin
                widx = (widx + 1) % 4;
                stall_cnt = 0;
            end
            if (!busy) begin
                widx = 0;
                stall_cnt = 0;
            end
            stalling = stall_mode && cfg_if.cfg_ready && (stall_cnt < 5);
            if (stalling) stall_cnt++;
            cfg_if.cfg_valid = !stalling;
            cfg_if.cfg_data  = words[widx];
            pend = cfg_if.cfg_valid && cfg_if.cfg_ready;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge prog_clk);
        cyc++;
        #1;
    endtask

    task automatic check_reset_vals(input string pfx);
        chk({pfx, "_cfg_ready"}, 32'(cfg_if.cfg_ready), 0);
        chk({pfx, "_head"}, 32'(ccff_head), 0);
        chk({pfx, "_shift_en"}, 32'(ccff_shift_en), 0);
        chk({pfx, "_busy"}, 32'(busy), 0);
        chk({pfx, "_done"}, 32'(done), 0);
        chk({pfx, "_err"}, 32'(err), 0);
        chk({pfx, "_err_count"}, 32'(err_count), 0);
    endtask

    // Cycle 1 is the edge that samples start; returns the first cycle with done high, or -1.
    task automatic run_load(input logic v, input int abort_at, input int start_at,
                            input int stop_at, output int done_cyc);
        en_base = en_cnt;
        cyc = 0;
        start = 1'b1; verify = v;
        tick();
        start = 1'b0; verify = 1'b0;
        done_cyc = -1;
        while (cyc < 200) begin
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (cyc == stop_at) break;
            abort = (cyc + 1 == abort_at);
            start = (cyc + 1 == start_at);
            tick();
        end
        abort = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; verify = 1'b0; abort = 1'b0;
        stall_mode = 1'b0; inj_en = 1'b0;
        repeat (3) tick();
        check_reset_vals("reset");
        reset = 1'b1;
        repeat (2) tick();

        // Load only
        run_load(1'b0, 0, 0, 0, dc);
        chk("load_done_cycle", 32'(dc), 34);
        chk("load_enables", 32'(en_cnt - en_base), 29);
        chk("load_chain", 32'(chain), 32'(EXP_CHAIN));
        tick();

        // Verify on a clean chain, with a stray start at cycle 5 that must be ignored
        run_load(1'b1, 0, 5, 0, dc);
        chk("verify_done_cycle", 32'(dc), 67);
        chk("verify_err", 32'(err), 0);
        chk("verify_err_count", 32'(err_count), 0);
        chk("verify_enables", 32'(en_cnt - en_base), 58);
        chk("verify_chain", 32'(chain), 32'(EXP_CHAIN));
        tick();

        // Verify with two injected tail faults
        inj_en = 1'b1;
        run_load(1'b1, 0, 0, 0, dc);
        inj_en = 1'b0;
        chk("fault_done", 32'(done), 1);
        chk("fault_done_cycle", 32'(dc), 67);
        chk("fault_err", 32'(err), 1);
        chk("fault_err_count", 32'(err_count), 2);
        tick();

        // A new start clears the sticky error flags
        run_load(1'b0, 0, 0, 0, dc);
        chk("restart_err_cleared", 32'(err), 0);
        chk("restart_err_count_cleared", 32'(err_count), 0);
        tick();

        // Backpressure: 5 stalled cycles per FETCH
        stall_mode = 1'b1;
        stall_bad = 0;
        stall_cyc = 0;
        run_load(1'b0, 0, 0, 0, dc);
        stall_mode = 1'b0;
        tick();
        chk("bp_done_cycle", 32'(dc), 54);
        chk("bp_stall_cycles", 32'(stall_cyc), 20);
        chk("bp_shift_during_stall", 32'(stall_bad), 0);
        chk("bp_enables", 32'(en_cnt - en_base), 29);
        chk("bp_chain", 32'(chain), 32'(EXP_CHAIN));

        // Abort mid-shift at cycle 12, then a clean reload
        chain = '0;
        run_load(1'b0, 12, 0, 12, dc);
        chk("abort_cycle", 32'(cyc), 12);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_shift_en", 32'(ccff_shift_en), 0);
        chk("abort_cfg_ready", 32'(cfg_if.cfg_ready), 0);
        tick();
        chk("abort_idle_stays", 32'(busy), 0);
        run_load(1'b0, 0, 0, 0, dc);
        chk("reload_done_cycle", 32'(dc), 34);
        chk("reload_enables", 32'(en_cnt - en_base), 29);
        chk("reload_chain", 32'(chain), 32'(EXP_CHAIN));
        tick();

        // Reset during the verify pass after the first injected fault has counted
        inj_en = 1'b1;
        run_load(1'b1, 0, 0, 39, dc);
        chk("midverify_busy", 32'(busy), 1);
        chk("midverify_err_count", 32'(err_count), 1);
        reset = 1'b0;
        #1;
        check_reset_vals("midreset");
        inj_en = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ccff_chain_loader.md
# ccff_chain_loader

Configuration-chain loader for the fabric's `ccff_head`/`ccff_tail` scan chains. It accepts a bitstream as words over a valid/ready interface and serializes them onto a tile's configuration chain, one bit per enabled `prog_clk` cycle. An optional second pass re-shifts the same bitstream while comparing `ccff_tail` against `ccff_head`, which checks chain integrity without local storage. It sits between the programming host interface and a column of logical tiles.

## Interface
Parameters:
- `CHAIN_LEN`, 29, number of configuration flops in the driven chain (≥2).
- `WORD_W`, 8, bitstream word width (≥2).

Ports:
- `prog_clk`  in  1  programming clock; the block's only clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a load; sampled only in IDLE.
- `verify`  in  1  sampled with `start`; 1 = load pass followed by verify pass.
- `abort`  in  1  return to IDLE from any state.
- `cfg_data`  in  WORD_W  bitstream word; LSB is shifted first.
- `cfg_valid`  in  1  `cfg_data` is valid.
- `cfg_ready`  out  1  block accepts a word this cycle.
- `ccff_head`  out  1  serial data to the chain head.
- `ccff_tail`  in  1  serial data from the chain tail.
- `ccff_shift_en`  out  1  chain clock enable (external ICG on the chain's `prog_clk`).
- `busy`  out  1  high in FETCH/SHIFT.
- `done`  out  1  sticky completion flag, cleared by the next accepted `start`.
- `err`  out  1  sticky: at least one verify mismatch.
- `err_count`  out  8  verify mismatch count, saturating at 255.

## Operation
- States: IDLE, FETCH, SHIFT, DONE.
- IDLE:
  - `start`=1 latches `verify` and clears `done`, `err`, `err_count`, bit and pass counters.
  - Next state is FETCH.
- FETCH:
  - `cfg_ready`=1.
  - On `cfg_valid`&`cfg_ready`, the word is loaded into the shift buffer.
  - nbits = min(WORD_W, CHAIN_LEN − bits_shifted_this_pass).
  - Next state is SHIFT.
- SHIFT:
  - Each cycle: `ccff_shift_en`=1, `ccff_head`=buf[0], buffer shifts right, bit counter increments.
  - After nbits cycles:
    - If the pass bit counter is below CHAIN_LEN, go to FETCH.
    - Else, if this was pass 0 with `verify` latched, reset the bit counter, set pass=1 and go to FETCH.
    - Else go to DONE.
  - Unused upper bits of a pass's final word are discarded.
  - A pass never spans words: each pass starts on a fresh word, so ceil(CHAIN_LEN/WORD_W) words are needed per pass.
- Verify (pass 1):
  - The host resends the identical bitstream.
  - On every SHIFT cycle, `ccff_tail` ≠ `ccff_head` sets `err` and increments `err_count` (saturating).
  - This works because, with exactly CHAIN_LEN flops, the tail presents the bit shifted CHAIN_LEN cycles earlier.
  - The chain holds the same configuration after pass 1.
- DONE: `done`=1; `start` behaves as in IDLE.
- `abort`:
  - From any state, go to IDLE next cycle and force `ccff_shift_en`=0 and `cfg_ready`=0.
  - `done` stays 0; `err`/`err_count` hold their values.
  - Chain contents are undefined.
- Precedence and ignored inputs:
  - `abort` overrides `start` and `cfg_valid` in the same cycle.
  - `start` outside IDLE/DONE is ignored.
- When not shifting, `ccff_head`=0.

## Timing
- Reset values: `cfg_ready`=0, `ccff_head`=0, `ccff_shift_en`=0, `busy`=0, `done`=0, `err`=0, `err_count`=0; state IDLE.
- Reset asserted mid-operation returns to IDLE immediately; chain contents are undefined.
- All outputs are registered.
- `ccff_tail` is sampled combinationally in the same cycle as `ccff_shift_en`, before the chain's clock edge.
- Word handshake: a transfer completes on the rising edge where `cfg_valid`&`cfg_ready`.
- `cfg_ready` is deasserted throughout SHIFT, giving one FETCH cycle per word.
- A stalled FETCH (`cfg_valid`=0) holds state with `ccff_shift_en`=0.
- Latency with `cfg_valid` held high: `done` is high (cycle count from the edge that samples `start`):
  - 1 + W + CHAIN_LEN cycles for a single pass, where W = ceil(CHAIN_LEN/WORD_W).
  - 1 + 2(W + CHAIN_LEN) cycles with verify.
  - Defaults: 34 (load only) and 67 (verify).
- The first shifted bit reaches the deepest chain flop after CHAIN_LEN enables.

## Test plan
- **Load-only:** 29-bit shift-register chain model; CHAIN_LEN=29, WORD_W=8; words 0xA5,0x3C,0xFF,0x15 with `cfg_valid` held high.
  - `done`=1 at cycle 34.
  - Exactly 29 `ccff_shift_en` cycles.
  - Chain model equals bits 0x15[4:0],0xFF,0x3C,0xA5 in shift order.
  - Bits 0x15[7:5] are not shifted.
- **Verify, clean chain:** `verify`=1, same four words sent twice.
  - `done` at cycle 67.
  - `err`=0, `err_count`=0.
  - Chain model is unchanged from the load-only result.
- **Verify, injected fault:** flip `ccff_tail` on pass-1 bits 3 and 20.
  - `err`=1, `err_count`=2.
  - `done`=1.
- **Backpressure:** drop `cfg_valid` for 5 cycles in each FETCH.
  - `ccff_shift_en`=0 during the stalls.
  - `done` at cycle 34+20=54.
  - Chain contents are identical to the load-only case.
- **Abort mid-shift:** assert `abort` at cycle 12.
  - IDLE on the next cycle; `busy`=0, `done`=0, `ccff_shift_en`=0.
  - A subsequent `start` loads correctly from bit 0.
- **Reset mid-verify:** drive `reset` low at cycle 40.
  - All outputs return to their reset values immediately (`err_count`=0).
  - `start` while `busy` (at cycle 5) is ignored.
